// File: rtl/sw_input_capture.sv
// Input stage for the 8-bit input register: synchronises the slide switches and the
// "data ready" button, debounces the button and hands one switch byte per fresh press.
module sw_input_capture #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] sw_data,
   input  logic             sw_strobe,
   input  logic             rd_req,
   output logic [WIDTH-1:0] out_data,
   output logic             out_en,
   output logic             stall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HOLD  = 2'd2
   } state_t;

   logic [WIDTH-1:0] data_meta;
   logic [WIDTH-1:0] data_s;
   logic             strobe_meta;
   logic             strobe_s;
   logic             deb;
   logic             deb_next;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic             rise;
   logic             capture;
   state_t           state;
   state_t           state_next;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         data_meta   <= '0;
         data_s      <= '0;
         strobe_meta <= 1'b0;
         strobe_s    <= 1'b0;
      end else begin
         data_meta   <= sw_data;
         data_s      <= data_meta;
         strobe_meta <= sw_strobe;
         strobe_s    <= strobe_meta;
      end
   end

   // Counter only runs while the synchronised level disagrees with deb; any agreement restarts it.
   always_comb begin
      deb_next = deb;
      cnt_next = '0;
      if (strobe_s != deb) begin
         if (cnt == CNT_LAST) begin
            deb_next = ~deb;
         end else begin
            cnt_next = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         deb  <= 1'b0;
         cnt  <= '0;
         rise <= 1'b0;
      end else begin
         deb  <= deb_next;
         cnt  <= cnt_next;
         rise <= ~deb & deb_next;
      end
   end

   // A withdrawn request wins over a coincident rise so nothing is written unrequested.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) state_next = ARMED;
         end
         ARMED: begin
            if (!rd_req) begin
               state_next = IDLE;
            end else if (rise) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (!deb) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         out_en   <= 1'b0;
         out_data <= '0;
      end else begin
         state  <= state_next;
         out_en <= capture;
         if (capture) out_data <= data_s;
      end
   end

   // Release the core during the write cycle so it advances while the register loads.
   assign stall = rd_req & ~out_en;

endmodule

// File: tb/tb_sw_input_capture.sv
// Directed bench for sw_input_capture: expected capture bytes are queued at each press
// and compared whenever out_en pulses; timing and stall behaviour are checked inline.
module tb_sw_input_capture;

   localparam int W = 8;
   localparam int LAT = 6;  // out_en is seen after edge E0+6, i.e. sampled by the register at E0+7

   logic         clk = 1'b0;
   logic         n_reset;
   logic [W-1:0] sw_data;
   logic         sw_strobe;
   logic         rd_req;
   logic [W-1:0] out_data;
   logic         out_en;
   logic         stall;

   logic [W-1:0] exp_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           en_count = 0;

   sw_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .sw_data  (sw_data),
      .sw_strobe(sw_strobe),
      .rd_req   (rd_req),
      .out_data (out_data),
      .out_en   (out_en),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: active edge, then sample on the falling edge and score any capture pulse.
   task automatic tick();
      logic [W-1:0] exp_v;
      @(posedge clk);
      @(negedge clk);
      if (out_en === 1'b1) begin
         en_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_out_en", 32'(out_en), 32'd0);
         end else begin
            exp_v = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(exp_v));
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Call right after driving a press; the first tick is edge E0.
   task automatic wait_en(input string tag, input int budget);
      int lat;
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (out_en === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      if (lat >= 0) check({tag, "_stall_at_en"}, 32'(stall), 32'd0);
   endtask

   task automatic release_button();
      sw_strobe = 1'b0;
      ticks(10);
   endtask

   initial begin
      int base;
      logic [W-1:0] last_val;
      n_reset   = 1'b0;
      sw_data   = '0;
      sw_strobe = 1'b0;
      rd_req    = 1'b0;
      ticks(3);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_en", 32'(out_en), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      n_reset = 1'b1;
      ticks(3);

      // Basic capture with per-cycle timing of out_en and stall
      sw_data = 8'hA5;
      rd_req  = 1'b1;
      ticks(3);
      check("basic_stall_wait", 32'(stall), 32'd1);
      sw_strobe = 1'b1;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("basic_en_k%0d", k), 32'(out_en), 32'(k == LAT));
         check($sformatf("basic_stall_k%0d", k), 32'(stall), 32'(k != LAT));
      end
      rd_req = 1'b0;
      release_button();
      check("basic_count", 32'(en_count), 32'd1);

      // Bounce: toggle every 2 cycles for 20 cycles, then stable high
      sw_data = 8'h5A;
      rd_req  = 1'b1;
      ticks(2);
      for (int p = 0; p < 10; p++) begin
         sw_strobe = ~sw_strobe;
         ticks(2);
      end
      check("bounce_no_en", 32'(en_count), 32'd1);
      sw_strobe = 1'b1;
      exp_q.push_back(8'h5A);
      wait_en("bounce", 20);
      rd_req = 1'b0;
      release_button();
      check("bounce_count", 32'(en_count), 32'd2);

      // 3-cycle glitch while armed must not capture
      sw_data = 8'hC3;
      rd_req  = 1'b1;
      ticks(2);
      sw_strobe = 1'b1;
      ticks(3);
      sw_strobe = 1'b0;
      ticks(15);
      check("glitch_count", 32'(en_count), 32'd2);
      check("glitch_stall", 32'(stall), 32'd1);

      // Withdrawn request, then a press: nothing captured, back in IDLE
      rd_req = 1'b0;
      ticks(2);
      sw_strobe = 1'b1;
      ticks(12);
      rd_req = 1'b1;
      ticks(10);
      check("withdraw_count", 32'(en_count), 32'd2);
      check("withdraw_data_kept", 32'(out_data), 32'h5A);
      check("withdraw_stall", 32'(stall), 32'd1);
      rd_req = 1'b0;
      release_button();

      // Held button before the request does not count; a fresh press does
      sw_strobe = 1'b1;
      ticks(12);
      sw_data = 8'h3C;
      rd_req  = 1'b1;
      ticks(15);
      check("held_no_en", 32'(en_count), 32'd2);
      check("held_stall", 32'(stall), 32'd1);
      release_button();
      check("held_release_no_en", 32'(en_count), 32'd2);
      sw_strobe = 1'b1;
      exp_q.push_back(8'h3C);
      wait_en("held", 20);
      rd_req = 1'b0;
      release_button();

      // Back-to-back reads; the second request arrives during HOLD
      sw_data = 8'h01;
      rd_req  = 1'b1;
      ticks(2);
      sw_strobe = 1'b1;
      exp_q.push_back(8'h01);
      wait_en("b2b_first", 20);
      sw_data = 8'hFF;
      ticks(8);
      check("b2b_hold_stall", 32'(stall), 32'd1);
      check("b2b_hold_count", 32'(en_count), 32'd4);
      release_button();
      check("b2b_release_count", 32'(en_count), 32'd4);
      sw_strobe = 1'b1;
      exp_q.push_back(8'hFF);
      wait_en("b2b_second", 20);
      rd_req = 1'b0;
      release_button();

      // Reset mid-ARMED with the button held: immediate clear, no pulse, fresh press needed
      sw_data = 8'h99;
      rd_req  = 1'b1;
      ticks(2);
      sw_strobe = 1'b1;
      ticks(3);
      n_reset = 1'b0;
      rd_req  = 1'b0;
      #1;
      check("midreset_out_data", 32'(out_data), 32'd0);
      check("midreset_out_en", 32'(out_en), 32'd0);
      check("midreset_stall", 32'(stall), 32'd0);
      base = en_count;
      ticks(3);
      n_reset = 1'b1;
      ticks(12);
      rd_req = 1'b1;
      ticks(15);
      check("postreset_no_en", 32'(en_count), 32'(base));
      check("postreset_stall", 32'(stall), 32'd1);
      last_val = out_data;
      check("postreset_data", 32'(last_val), 32'd0);
      release_button();
      sw_strobe = 1'b1;
      exp_q.push_back(8'h99);
      wait_en("postreset", 20);
      rd_req = 1'b0;
      release_button();

      check("total_pulses", 32'(en_count), 32'd6);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
